// File: rtl/dual_issue_pkg.sv
// Shared types and helpers for the dual-issue scheduler slice.
package dual_issue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAIR   = 2'd1,
        SECOND = 2'd2
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwr;
        logic       memrd;
        logic       memwr;
    } slot_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when either source names rd and rd is a real (nonzero) register.
    function automatic logic reads_reg(input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic [4:0] rd);
        return (rd != REG_ZERO) && ((rs1 == rd) || (rs2 == rd));
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_scoreboard.sv
// Load scoreboard: a LOAD_LAT-deep shift register of recently decided
// loads, queried by two instructions for load-use hazards.
module load_scoreboard
    import dual_issue_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       load_v,
    input  logic [4:0] load_rd,
    input  logic [4:0] qa_rs1,
    input  logic [4:0] qa_rs2,
    output logic       qa_haz,
    input  logic [4:0] qb_rs1,
    input  logic [4:0] qb_rs2,
    output logic       qb_haz
);

    logic [LOAD_LAT-1:0]      ent_v;
    logic [LOAD_LAT-1:0][4:0] ent_rd;

    // Shift in the load decided this cycle; the oldest entry falls off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v  <= '0;
            ent_rd <= '0;
        end else if (shift_en) begin
            ent_v[0]  <= load_v;
            ent_rd[0] <= load_rd;
            for (int i = 1; i < LOAD_LAT; i++) begin
                ent_v[i]  <= ent_v[i-1];
                ent_rd[i] <= ent_rd[i-1];
            end
        end
    end

    // Both sources are always compared, even if the instruction ignores one.
    always_comb begin
        qa_haz = 1'b0;
        qb_haz = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (ent_v[i] && reads_reg(qa_rs1, qa_rs2, ent_rd[i])) qa_haz = 1'b1;
            if (ent_v[i] && reads_reg(qb_rs1, qb_rs2, ent_rd[i])) qb_haz = 1'b1;
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: buffers a decoded pair and issues it on lane 0
// (ALU + memory) and lane 1 (ALU only), splitting the pair on hazards.
// Handshake: a pair transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid and the decoder must hold the pair
// until it transfers.
module dual_issue_scheduler
    import dual_issue_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0_v,
    input  logic [4:0]       s0_rs1,
    input  logic [4:0]       s0_rs2,
    input  logic [4:0]       s0_rd,
    input  logic             s0_regwr,
    input  logic             s0_memrd,
    input  logic             s0_memwr,
    input  logic             s1_v,
    input  logic [4:0]       s1_rs1,
    input  logic [4:0]       s1_rs2,
    input  logic [4:0]       s1_rd,
    input  logic             s1_regwr,
    input  logic             s1_memrd,
    input  logic             s1_memwr,
    input  logic             stall,
    output logic             l0_v,
    output logic [4:0]       l0_rs1,
    output logic [4:0]       l0_rs2,
    output logic [4:0]       l0_rd,
    output logic             l0_regwr,
    output logic             l0_memrd,
    output logic             l0_memwr,
    output logic             l0_slot,
    output logic             l1_v,
    output logic [4:0]       l1_rs1,
    output logic [4:0]       l1_rs2,
    output logic [4:0]       l1_rd,
    output logic             l1_regwr,
    output logic [CNT_W-1:0] split_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state, state_n;
    slot_t  b0, b1;
    slot_t  in_s0, in_s1;
    slot_t  l0_src;

    logic haz0, haz1, raw, waw;
    logic issue0, co_issue, issue_second, drain, l0_go;
    logic accept, split_ev, stall_ev, load_v;

    assign in_s0 = {s0_v, s0_rs1, s0_rs2, s0_rd, s0_regwr, s0_memrd, s0_memwr};
    assign in_s1 = {s1_v, s1_rs1, s1_rs2, s1_rd, s1_regwr, s1_memrd, s1_memwr};

    load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (!stall),
        .load_v   (load_v),
        .load_rd  (l0_src.rd),
        .qa_rs1   (b0.rs1),
        .qa_rs2   (b0.rs2),
        .qa_haz   (haz0),
        .qb_rs1   (b1.rs1),
        .qb_rs2   (b1.rs2),
        .qb_haz   (haz1)
    );

    // Issue decision for the buffered instructions, plus the accept rule.
    always_comb begin
        raw          = b0.regwr && reads_reg(b1.rs1, b1.rs2, b0.rd);
        waw          = b0.regwr && b1.regwr && (b0.rd != REG_ZERO) && (b0.rd == b1.rd);
        issue0       = (state == PAIR) && b0.v && !haz0;
        co_issue     = issue0 && b1.v && !b1.memrd && !b1.memwr && !raw && !waw && !haz1;
        issue_second = (state == SECOND) && !haz1;
        drain        = (issue0 && (!b1.v || co_issue)) || issue_second;
        l0_go        = issue0 || issue_second;
        l0_src       = issue0 ? b0 : b1;
        load_v       = l0_go && l0_src.memrd && l0_src.regwr;
        in_ready     = rst_n && !stall && ((state == IDLE) || drain);
        accept       = in_valid && in_ready;
        split_ev     = issue0 && b1.v && !co_issue;
        stall_ev     = (state != IDLE) && !l0_go;
    end

    // Next state: a drained buffer refills from the handshake on the same edge.
    always_comb begin
        state_n = state;
        if ((state == IDLE) || drain) begin
            if (accept) state_n = s0_v ? PAIR : (s1_v ? SECOND : IDLE);
            else        state_n = IDLE;
        end else if (issue0) begin
            state_n = SECOND;
        end
    end

    // State and pair buffer; everything freezes while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            b0    <= '0;
            b1    <= '0;
        end else if (!stall) begin
            state <= state_n;
            if (accept) begin
                b0 <= in_s0;
                b1 <= in_s1;
            end
        end
    end

    // Registered lane outputs; a lane that issues nothing shows all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l0_v     <= 1'b0;
            l0_rs1   <= REG_ZERO;
            l0_rs2   <= REG_ZERO;
            l0_rd    <= REG_ZERO;
            l0_regwr <= 1'b0;
            l0_memrd <= 1'b0;
            l0_memwr <= 1'b0;
            l0_slot  <= 1'b0;
            l1_v     <= 1'b0;
            l1_rs1   <= REG_ZERO;
            l1_rs2   <= REG_ZERO;
            l1_rd    <= REG_ZERO;
            l1_regwr <= 1'b0;
        end else if (!stall) begin
            l0_v     <= l0_go && l0_src.v;
            l0_rs1   <= l0_go ? l0_src.rs1 : REG_ZERO;
            l0_rs2   <= l0_go ? l0_src.rs2 : REG_ZERO;
            l0_rd    <= l0_go ? l0_src.rd : REG_ZERO;
            l0_regwr <= l0_go && l0_src.regwr;
            l0_memrd <= l0_go && l0_src.memrd;
            l0_memwr <= l0_go && l0_src.memwr;
            l0_slot  <= issue_second;
            l1_v     <= co_issue;
            l1_rs1   <= co_issue ? b1.rs1 : REG_ZERO;
            l1_rs2   <= co_issue ? b1.rs2 : REG_ZERO;
            l1_rd    <= co_issue ? b1.rd : REG_ZERO;
            l1_regwr <= co_issue && b1.regwr;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
            stall_cnt <= '0;
        end else if (!stall) begin
            if (split_ev && (split_cnt != '1)) split_cnt <= split_cnt + CNT_W'(1);
            if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: two instances (LOAD_LAT=1 and 2) share
// the same inputs; each is compared every cycle against an issue model.
module tb_dual_issue_scheduler;
    import dual_issue_pkg::*;

    logic clk = 1'b0;
    logic rst_n, in_valid, stall;
    slot_t in0, in1;

    logic [1:0]            in_ready, l0_v, l0_regwr, l0_memrd, l0_memwr, l0_slot;
    logic [1:0]            l1_v, l1_regwr;
    logic [1:0][4:0]       l0_rs1, l0_rs2, l0_rd, l1_rs1, l1_rs2, l1_rd;
    logic [1:0][31:0]      split_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dual_issue_scheduler #(.LOAD_LAT(g + 1), .CNT_W(32)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .s0_v      (in0.v),
            .s0_rs1    (in0.rs1),
            .s0_rs2    (in0.rs2),
            .s0_rd     (in0.rd),
            .s0_regwr  (in0.regwr),
            .s0_memrd  (in0.memrd),
            .s0_memwr  (in0.memwr),
            .s1_v      (in1.v),
            .s1_rs1    (in1.rs1),
            .s1_rs2    (in1.rs2),
            .s1_rd     (in1.rd),
            .s1_regwr  (in1.regwr),
            .s1_memrd  (in1.memrd),
            .s1_memwr  (in1.memwr),
            .stall     (stall),
            .l0_v      (l0_v[g]),
            .l0_rs1    (l0_rs1[g]),
            .l0_rs2    (l0_rs2[g]),
            .l0_rd     (l0_rd[g]),
            .l0_regwr  (l0_regwr[g]),
            .l0_memrd  (l0_memrd[g]),
            .l0_memwr  (l0_memwr[g]),
            .l0_slot   (l0_slot[g]),
            .l1_v      (l1_v[g]),
            .l1_rs1    (l1_rs1[g]),
            .l1_rs2    (l1_rs2[g]),
            .l1_rd     (l1_rd[g]),
            .l1_regwr  (l1_regwr[g]),
            .split_cnt (split_cnt[g]),
            .stall_cnt (stall_cnt[g])
        );
    end

    // Model state per instance: pending slots, per-register last load tick.
    slot_t       m_b0[2], m_b1[2];
    bit          m_h0[2], m_h1[2];
    longint      m_tick[2];
    longint      m_ld[2][32];
    logic [19:0] e_l0[2];
    logic [16:0] e_l1[2];
    logic [31:0] e_split[2], e_stall[2];
    logic        e_rdy[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t mk(input bit v, input int rs1, input int rs2, input int rd,
                                 input bit regwr, input bit memrd, input bit memwr);
        slot_t s;
        s.v = v; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.regwr = regwr; s.memrd = memrd; s.memwr = memwr;
        return s;
    endfunction

    function automatic slot_t rnd_slot();
        slot_t s;
        int m;
        s.v     = ($urandom_range(0, 9) != 0);
        s.rs1   = 5'($urandom_range(0, 7));
        s.rs2   = 5'($urandom_range(0, 7));
        s.rd    = 5'($urandom_range(0, 7));
        m       = $urandom_range(0, 7);
        s.memrd = (m < 2);
        s.memwr = (m == 2);
        s.regwr = s.memwr ? 1'b0 : ($urandom_range(0, 4) != 0);
        return s;
    endfunction

    // A source is blocked while a load to it was decided within the last LOAD_LAT ticks.
    function automatic bit m_haz(input int k, input slot_t s);
        if (s.rs1 != 5'd0 && (m_tick[k] - m_ld[k][s.rs1]) <= longint'(k + 1)) return 1'b1;
        if (s.rs2 != 5'd0 && (m_tick[k] - m_ld[k][s.rs2]) <= longint'(k + 1)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input int k);
        bit busy, h0, h1, co, raw, waw;
        logic [19:0] nl0;
        logic [16:0] nl1;
        slot_t s;
        if (!rst_n) begin
            m_h0[k] = 0; m_h1[k] = 0;
            e_l0[k] = '0; e_l1[k] = '0; e_split[k] = '0; e_stall[k] = '0; e_rdy[k] = 0;
            for (int r = 0; r < 32; r++) m_ld[k][r] = -100;
            return;
        end
        if (stall) begin
            e_rdy[k] = 0;
            return;
        end
        busy = m_h0[k] || m_h1[k];
        h0 = m_haz(k, m_b0[k]);
        h1 = m_haz(k, m_b1[k]);
        nl0 = '0;
        nl1 = '0;
        s = '0;
        if (m_h0[k]) begin
            if (!h0) begin
                s = m_b0[k];
                nl0 = {1'b1, s.rs1, s.rs2, s.rd, s.regwr, s.memrd, s.memwr, 1'b0};
                m_h0[k] = 0;
                if (m_h1[k]) begin
                    raw = s.regwr && s.rd != 0 && (s.rd == m_b1[k].rs1 || s.rd == m_b1[k].rs2);
                    waw = s.regwr && m_b1[k].regwr && s.rd != 0 && s.rd == m_b1[k].rd;
                    co  = !m_b1[k].memrd && !m_b1[k].memwr && !raw && !waw && !h1;
                    if (co) begin
                        nl1 = {1'b1, m_b1[k].rs1, m_b1[k].rs2, m_b1[k].rd, m_b1[k].regwr};
                        m_h1[k] = 0;
                    end else begin
                        e_split[k]++;
                    end
                end
            end
        end else if (m_h1[k]) begin
            if (!h1) begin
                s = m_b1[k];
                nl0 = {1'b1, s.rs1, s.rs2, s.rd, s.regwr, s.memrd, s.memwr, 1'b1};
                m_h1[k] = 0;
            end
        end
        if (nl0[19] && s.memrd && s.regwr) m_ld[k][s.rd] = m_tick[k];
        if (busy && !nl0[19]) e_stall[k]++;
        e_rdy[k] = !m_h0[k] && !m_h1[k];
        if (in_valid && e_rdy[k]) begin
            m_b0[k] = in0; m_b1[k] = in1;
            m_h0[k] = in0.v; m_h1[k] = in1.v;
        end
        e_l0[k] = nl0;
        e_l1[k] = nl1;
        m_tick[k]++;
    endtask

    // One clock: inputs already driven; check in_ready, clock, check outputs.
    task automatic cyc();
        #2;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            chk($sformatf("in_ready[%0d]", k), in_ready[k], e_rdy[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lane0[%0d]", k),
                {l0_v[k], l0_rs1[k], l0_rs2[k], l0_rd[k], l0_regwr[k], l0_memrd[k], l0_memwr[k], l0_slot[k]},
                e_l0[k]);
            chk($sformatf("lane1[%0d]", k),
                {l1_v[k], l1_rs1[k], l1_rs2[k], l1_rd[k], l1_regwr[k]}, e_l1[k]);
            chk($sformatf("split_cnt[%0d]", k), split_cnt[k], e_split[k]);
            chk($sformatf("stall_cnt[%0d]", k), stall_cnt[k], e_stall[k]);
        end
    endtask

    task automatic send(input slot_t a, input slot_t b);
        in_valid = 1'b1; in0 = a; in1 = b;
        cyc();
        in_valid = 1'b0; in0 = '0; in1 = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    logic [31:0] snap_split[2], snap_stall[2];

    initial begin
        for (int k = 0; k < 2; k++) m_tick[k] = 0;
        rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0;
        idle(2);
        chk("rst_l0v", l0_v[0], 1'b0);
        chk("rst_in_ready", in_ready[0], 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Independent ALU pair: co-issue one cycle after accept.
        snap_split[0] = split_cnt[0];
        send(mk(1, 2, 3, 1, 1, 0, 0), mk(1, 5, 6, 4, 1, 0, 0));
        idle(1);
        chk("ind_l0v", l0_v[0], 1'b1);
        chk("ind_l1v", l1_v[0], 1'b1);
        chk("ind_slot", l0_slot[0], 1'b0);
        chk("ind_split", split_cnt[0] - snap_split[0], 0);
        idle(3);

        // RAW pair: split, slot 1 follows on lane 0.
        snap_split[0] = split_cnt[0];
        send(mk(1, 1, 2, 5, 1, 0, 0), mk(1, 5, 3, 6, 1, 0, 0));
        idle(1);
        chk("raw_first_l1v", l1_v[0], 1'b0);
        chk("raw_first_slot", l0_slot[0], 1'b0);
        idle(1);
        chk("raw_second_l0v", l0_v[0], 1'b1);
        chk("raw_second_slot", l0_slot[0], 1'b1);
        chk("raw_second_l1v", l1_v[0], 1'b0);
        chk("raw_split", split_cnt[0] - snap_split[0], 1);
        idle(3);

        // Load then store: split, both on lane 0.
        send(mk(1, 2, 0, 8, 1, 1, 0), mk(1, 3, 9, 0, 0, 0, 1));
        idle(1);
        chk("mem_load", l0_memrd[0], 1'b1);
        chk("mem_load_l1v", l1_v[0], 1'b0);
        idle(1);
        chk("mem_store", l0_memwr[0], 1'b1);
        idle(3);

        // Load-use across pairs: LOAD_LAT bubbles in each instance.
        for (int k = 0; k < 2; k++) snap_stall[k] = stall_cnt[k];
        send(mk(1, 1, 2, 7, 1, 1, 0), '0);
        send(mk(1, 3, 7, 12, 1, 0, 0), '0);
        idle(5);
        chk("lu_bubbles_lat1", stall_cnt[0] - snap_stall[0], 1);
        chk("lu_bubbles_lat2", stall_cnt[1] - snap_stall[1], 2);

        // x0 never creates a dependency.
        snap_split[0] = split_cnt[0];
        send(mk(1, 1, 2, 0, 1, 0, 0), mk(1, 0, 3, 10, 1, 0, 0));
        idle(1);
        chk("x0_coissue", l1_v[0], 1'b1);
        chk("x0_split", split_cnt[0] - snap_split[0], 0);
        idle(3);
        for (int k = 0; k < 2; k++) snap_stall[k] = stall_cnt[k];
        send(mk(1, 2, 3, 0, 1, 1, 0), '0);
        send(mk(1, 0, 0, 11, 1, 0, 0), '0);
        idle(4);
        chk("x0_load_lat1", stall_cnt[0] - snap_stall[0], 0);
        chk("x0_load_lat2", stall_cnt[1] - snap_stall[1], 0);

        // Stall for 3 cycles while in SECOND.
        send(mk(1, 1, 2, 5, 1, 0, 0), mk(1, 5, 3, 6, 1, 0, 0));
        idle(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold_slot", l0_slot[0], 1'b0);
        end
        stall = 1'b0;
        idle(1);
        chk("stall_release_slot", l0_slot[0], 1'b1);
        idle(3);

        // Reset pulse while a pair is buffered.
        send(mk(1, 2, 3, 1, 1, 0, 0), mk(1, 5, 6, 4, 1, 0, 0));
        rst_n = 1'b0;
        idle(1);
        chk("midrst_l0v", l0_v[0], 1'b0);
        chk("midrst_l1v", l1_v[0], 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("postrst_l0v", l0_v[0], 1'b0);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 5) == 0);
            rst_n    = ($urandom_range(0, 199) != 0);
            in0      = rnd_slot();
            in1      = rnd_slot();
            cyc();
        end
        rst_n = 1'b1; stall = 1'b0; in_valid = 1'b0;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue scheduler for the dual-issue decode stage. Accepts a decoded instruction pair (older slot 0, younger slot 1), buffers it, and issues it on two lanes. Lane 0 has ALU and memory access; lane 1 is ALU-only. The pair is split when an intra-pair hazard, a structural conflict, or a load-use hazard prevents co-issue. Sits between the pair decoder and the register-read/execute stage.

## Interface
- LOAD_LAT, 1: bubble cycles a load's rd stays unavailable after the load's issue decision (1..3).
- CNT_W, 32: width of the stall/split counters.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoder presents a pair
- in_ready  out  1  scheduler accepts the pair this cycle
- s0_v, s1_v  in  1 each  slot holds a real instruction (encoding nonzero)
- s0_rs1, s0_rs2, s0_rd, s1_rs1, s1_rs2, s1_rd  in  5 each  register indices
- s0_regwr, s0_memrd, s0_memwr, s1_regwr, s1_memrd, s1_memwr  in  1 each  decoded controls
- stall  in  1  downstream freeze; no decision, outputs hold
- l0_v, l1_v  out  1 each  lane carries an instruction this cycle (registered)
- l0_rs1, l0_rs2, l0_rd, l1_rs1, l1_rs2, l1_rd  out  5 each  lane register indices (registered)
- l0_regwr, l0_memrd, l0_memwr, l1_regwr  out  1 each  lane controls (registered)
- l0_slot  out  1  0 = lane 0 carries slot 0, 1 = lane 0 carries slot 1
- split_cnt, stall_cnt  out  CNT_W each  performance counters

## Operation
- States:
  - IDLE: nothing buffered.
  - PAIR: both slots buffered, neither issued.
  - SECOND: slot 1 buffered; slot 0 already issued.
- Accept rule: in_ready = !stall && (state==IDLE || the buffer fully drains this cycle). A handshake (in_valid && in_ready) latches the pair. The next state is PAIR, or SECOND if s0_v=0. A pair with both v=0 is dropped and the state stays IDLE.
- Load-use hazard for an instruction:
  - Its rs1 or rs2 equals the rd of a scoreboard entry, and that rd is nonzero.
  - Both sources are always compared (conservative).
- Scoreboard: LOAD_LAT-deep shift register of (valid, rd).
  - Each non-stalled cycle, it shifts in (issued memrd && regwr, rd) of the load decided that cycle.
  - At most one load is decided per cycle, always on lane 0.
- PAIR decision:
  - Slot 0 issues on lane 0 if it has no load-use hazard.
  - Slot 1 co-issues on lane 1 only if all of the following hold:
    - slot 0 issues;
    - s1_memrd = s1_memwr = 0;
    - no RAW: s0_regwr, s0_rd != 0, and s0_rd matches s1_rs1 or s1_rs2;
    - no WAW: both regwr and equal nonzero rd;
    - slot 1 has no load-use hazard.
  - Both issue -> IDLE. Only slot 0 issues -> SECOND and split_cnt increments. Neither issues -> stay.
- SECOND decision: slot 1 issues on lane 0 (l0_slot=1) when it has no load-use hazard, then -> IDLE.
- stall_cnt increments each non-stalled cycle in which an instruction is buffered and nothing issues.
- Both counters saturate at all-ones.
- stall=1 behaviour:
  - State, buffer, scoreboard and counters freeze.
  - Lane outputs hold their last values.
  - in_ready=0.

## Timing
- Decision at edge N appears on the lane outputs after edge N+1. Latency from the accept edge to l0_v is 1 cycle minimum.
- A dependent of a load decided at cycle t is decided no earlier than t+LOAD_LAT+1. This gives exactly LOAD_LAT lane bubbles.
- Same-cycle refill: when the buffer drains and in_valid=1, the new pair is latched on the same edge. Pairs stream back-to-back with no bubble.
- Reset values:
  - state IDLE, buffer invalid, scoreboard all invalid;
  - every lane output 0, l0_slot 0;
  - counters 0;
  - in_ready 0 while rst_n=0, then 1 in the first cycle after release.
- Reset asserted mid-pair discards the buffered instructions. No partial issue completes.

## Structure
- Shared package dual_issue_pkg:
  - state enum {IDLE, PAIR, SECOND};
  - packed struct slot_t {v, rs1, rs2, rd, regwr, memrd, memwr};
  - localparam REG_ZERO = 5'd0.
- Sub-module load_scoreboard (LOAD_LAT parameter). Ports: clk, rst_n, shift enable, load-in (v, rd), two query ports each returning a hazard bit.
- Intra-pair hazard checks stay combinational in the top module.

## Test plan
- Independent ALU pair (add x1,x2,x3 / add x4,x5,x6), stall=0: l0_v=l1_v=1 one cycle after accept, l0_slot=0, in_ready stays 1, split_cnt=0.
- RAW pair (s0 rd=5 regwr / s1 rs1=5): l0 carries slot 0, next cycle l0 carries slot 1 with l0_slot=1, l1_v=0 both cycles, split_cnt=1.
- Two memory ops (lw / sw): split; the load is on lane 0 first, the store on lane 0 the following cycle.
- Load-use across pairs (lw x7 in slot 0, next pair s0 rs2=7), LOAD_LAT=1: exactly one cycle with l0_v=l1_v=0, stall_cnt=1; repeat with LOAD_LAT=2 -> 2 bubbles, stall_cnt=2.
- rd=x0 cases:
  - s0 rd=0 regwr, s1 rs1=0: co-issue, no split.
  - lw x0 followed by a user of x0: no bubble.
- Mid-operation events:
  - stall asserted for 3 cycles in SECOND: outputs hold, counters unchanged, slot 1 issues the cycle after release.
  - rst_n pulsed low in PAIR: all lane outputs 0, no slot issues after release until a new accept.
